// File: rtl/layer_norm_row_streamer_if.sv
// Row-stream bundle between the frame streamer and downstream row-wise units.
// The master side captures frames and sources rows; the slave side supplies frames and accepts rows.
interface layer_norm_row_streamer_if #(
    parameter int MATRIX_SIZE   = 64,
    parameter int Y_WIDTH       = 16,
    parameter int ROW_IDX_WIDTH = $clog2(MATRIX_SIZE)
);
    logic                                     matrix_valid_in;
    logic [MATRIX_SIZE*MATRIX_SIZE*Y_WIDTH-1:0] y_matrix_flat_in;
    logic                                     row_ready_in;
    logic                                     row_valid_out;
    logic [MATRIX_SIZE*Y_WIDTH-1:0]           row_data_out;
    logic [ROW_IDX_WIDTH-1:0]                 row_index_out;
    logic                                     row_last_out;

    modport master (
        input  matrix_valid_in, y_matrix_flat_in, row_ready_in,
        output row_valid_out, row_data_out, row_index_out, row_last_out
    );

    modport slave (
        output matrix_valid_in, y_matrix_flat_in, row_ready_in,
        input  row_valid_out, row_data_out, row_index_out, row_last_out
    );
endinterface

// File: rtl/layer_norm_row_streamer.sv
// Captures a completed LayerNorm output frame and replays it one row per valid/ready transfer.
// Frames arriving mid-replay are dropped and counted; a frame arriving on the final transfer chains in.
module layer_norm_row_streamer #(
    parameter int MATRIX_SIZE   = 64,
    parameter int Y_WIDTH       = 16,
    parameter int ROW_IDX_WIDTH = $clog2(MATRIX_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    layer_norm_row_streamer_if.master  bus,
    output logic                       frame_done_out,
    output logic                       busy_out,
    output logic [7:0]                 overrun_count_out
);
    localparam int ROW_W = MATRIX_SIZE * Y_WIDTH;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]                          state;
    logic [ROW_IDX_WIDTH-1:0]            row_cnt;
    logic [MATRIX_SIZE-1:0][ROW_W-1:0]   frame_buf;

    logic xfer;
    logic last_row;
    logic final_xfer;
    logic capture;
    logic drop;

    assign xfer       = (state == STREAM) && bus.row_ready_in;
    assign last_row   = (row_cnt == ROW_IDX_WIDTH'(MATRIX_SIZE - 1));
    assign final_xfer = xfer && last_row;
    // A frame landing on the final transfer is accepted, so replay continues without a bubble.
    assign capture    = bus.matrix_valid_in && ((state == IDLE) || final_xfer);
    assign drop       = bus.matrix_valid_in && (state == STREAM) && !final_xfer;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            row_cnt           <= '0;
            // NOTE: the frame buffer is reset too, so row_data_out reads zero after reset.
            frame_buf         <= '0;
            frame_done_out    <= 1'b0;
            overrun_count_out <= 8'd0;
        end else begin
            frame_done_out <= final_xfer;

            if (capture) begin
                frame_buf <= bus.y_matrix_flat_in;
            end

            if (drop && (overrun_count_out != 8'hFF)) begin
                overrun_count_out <= overrun_count_out + 8'd1;
            end

            if (capture) begin
                state   <= STREAM;
                row_cnt <= '0;
            end else if (final_xfer) begin
                state   <= IDLE;
                row_cnt <= '0;
            end else if (xfer) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // Row outputs depend only on registered state; row_ready_in never reaches the data mux.
    assign bus.row_valid_out = (state == STREAM);
    assign busy_out          = (state == STREAM);
    assign bus.row_data_out  = frame_buf[row_cnt];
    assign bus.row_index_out = row_cnt;
    assign bus.row_last_out  = (state == STREAM) && last_row;
endmodule

// File: tb/tb_layer_norm_row_streamer.sv
// Directed bench for layer_norm_row_streamer: full-size instance plus a 4x4x8 instance.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_layer_norm_row_streamer;
    localparam int N   = 64;
    localparam int W   = 16;
    localparam int RW  = N * W;
    localparam int NS  = 4;
    localparam int WS  = 8;
    localparam int RWS = NS * WS;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_done, d_busy;
    logic [7:0] d_ovr;
    logic       s_done, s_busy;
    logic [7:0] s_ovr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    layer_norm_row_streamer_if #(.MATRIX_SIZE(N),  .Y_WIDTH(W))  d_bus ();
    layer_norm_row_streamer_if #(.MATRIX_SIZE(NS), .Y_WIDTH(WS)) s_bus ();

    layer_norm_row_streamer #(.MATRIX_SIZE(N), .Y_WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (d_bus),
        .frame_done_out    (d_done),
        .busy_out          (d_busy),
        .overrun_count_out (d_ovr)
    );

    layer_norm_row_streamer #(.MATRIX_SIZE(NS), .Y_WIDTH(WS)) dut_small (
        .clk               (clk),
        .rst               (rst),
        .bus               (s_bus),
        .frame_done_out    (s_done),
        .busy_out          (s_busy),
        .overrun_count_out (s_ovr)
    );

    // Pattern 0: r*64+c; pattern 1: all 0x7FFF; pattern 2: (r*64+c) ^ 0x5555.
    function automatic logic [RW-1:0] exp_row(int p, int r);
        logic [RW-1:0] v;
        logic [W-1:0]  e;
        for (int c = 0; c < N; c++) begin
            case (p)
                0:       e = W'(r * N + c);
                1:       e = 16'h7FFF;
                default: e = W'(r * N + c) ^ 16'h5555;
            endcase
            v[c*W +: W] = e;
        end
        return v;
    endfunction

    function automatic logic [N*RW-1:0] frame(int p);
        logic [N*RW-1:0] v;
        for (int r = 0; r < N; r++) v[r*RW +: RW] = exp_row(p, r);
        return v;
    endfunction

    function automatic logic [RWS-1:0] exp_srow(int f, int r);
        logic [RWS-1:0] v;
        for (int c = 0; c < NS; c++) v[c*WS +: WS] = WS'(f * 16 + r * NS + c + 1);
        return v;
    endfunction

    function automatic logic [NS*RWS-1:0] sframe(int f);
        logic [NS*RWS-1:0] v;
        for (int r = 0; r < NS; r++) v[r*RWS +: RWS] = exp_srow(f, r);
        return v;
    endfunction

    function automatic int bad_col(logic [RW-1:0] g, logic [RW-1:0] e);
        for (int c = 0; c < N; c++) if (g[c*W +: W] !== e[c*W +: W]) return c;
        return 0;
    endfunction

    task automatic pulse_frame(int p);
        d_bus.matrix_valid_in  = 1'b1;
        d_bus.y_matrix_flat_in = frame(p);
        @(negedge clk);
        d_bus.matrix_valid_in  = 1'b0;
    endtask

    task automatic drain_big(string name);
        int k = 0;
        d_bus.row_ready_in = 1'b1;
        while (d_done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (d_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_drain frame_done_out never seen (got %b, want 1)", name, d_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({d_bus.row_valid_out, d_busy, d_done, d_bus.row_last_out} !== 4'b0 ||
            d_bus.row_index_out !== '0 || d_ovr !== 8'd0 || d_bus.row_data_out !== '0) begin
            n_err++;
            $display("FAIL reset_state valid=%b busy=%b done=%b last=%b idx=%0d ovr=%0d (want all 0)",
                     d_bus.row_valid_out, d_busy, d_done, d_bus.row_last_out, d_bus.row_index_out, d_ovr);
        end
        d_bus.row_ready_in = 1'b1;
        pulse_frame(0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (d_bus.row_index_out !== 6'd5 || d_bus.row_valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_preload idx=%0d valid=%b (want 5, 1)", d_bus.row_index_out, d_bus.row_valid_out);
        end
        d_bus.row_ready_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({d_bus.row_valid_out, d_busy, d_done, d_bus.row_last_out} !== 4'b0 ||
                d_bus.row_index_out !== '0 || d_ovr !== 8'd0 || d_bus.row_data_out !== '0) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d valid=%b busy=%b done=%b idx=%0d ovr=%0d (want all 0)",
                         i, d_bus.row_valid_out, d_busy, d_done, d_bus.row_index_out, d_ovr);
            end
            d_bus.row_ready_in = i[0];
            @(negedge clk);
        end
    endtask

    task automatic test_full_rate();
        int bc;
        d_bus.row_ready_in = 1'b1;
        pulse_frame(0);
        for (int r = 0; r < N; r++) begin
            n_cmp++;
            if (d_bus.row_valid_out !== 1'b1 || d_busy !== 1'b1 || d_done !== 1'b0 ||
                d_bus.row_index_out !== 6'(r) || d_bus.row_last_out !== (r == N - 1)) begin
                n_err++;
                $display("FAIL full_ctrl row %0d valid=%b busy=%b done=%b idx=%0d last=%b (want 1,1,0,%0d,%b)",
                         r, d_bus.row_valid_out, d_busy, d_done, d_bus.row_index_out, d_bus.row_last_out,
                         r, (r == N - 1));
            end
            n_cmp++;
            if (d_bus.row_data_out !== exp_row(0, r)) begin
                n_err++;
                bc = bad_col(d_bus.row_data_out, exp_row(0, r));
                $display("FAIL full_data row %0d col %0d got %h want %h", r, bc,
                         d_bus.row_data_out[bc*W +: W], W'(r * N + bc));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (d_done !== 1'b1 || d_busy !== 1'b0 || d_bus.row_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL full_done done=%b busy=%b valid=%b (want 1,0,0)", d_done, d_busy, d_bus.row_valid_out);
        end
        @(negedge clk);
        n_cmp++;
        if (d_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_done_width done=%b (want 0)", d_done);
        end
    endtask

    task automatic test_backpressure();
        d_bus.row_ready_in = 1'b1;
        pulse_frame(0);
        repeat (10) @(negedge clk);
        d_bus.row_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (d_bus.row_index_out !== 6'd10 || d_bus.row_data_out !== exp_row(0, 10) ||
                d_bus.row_valid_out !== 1'b1 || d_bus.row_last_out !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d idx=%0d valid=%b data_ok=%b (want 10,1,1)",
                         i, d_bus.row_index_out, d_bus.row_valid_out, d_bus.row_data_out === exp_row(0, 10));
            end
            if (i == 3) d_bus.row_ready_in = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (d_bus.row_index_out !== 6'd11 || d_bus.row_data_out !== exp_row(0, 11)) begin
            n_err++;
            $display("FAIL bp_next idx=%0d data_ok=%b (want 11,1)",
                     d_bus.row_index_out, d_bus.row_data_out === exp_row(0, 11));
        end
        drain_big("bp");
    endtask

    task automatic test_overrun();
        d_bus.row_ready_in = 1'b1;
        pulse_frame(0);
        for (int r = 0; r < N; r++) begin
            n_cmp++;
            if (d_bus.row_index_out !== 6'(r) || d_bus.row_data_out !== exp_row(0, r)) begin
                n_err++;
                $display("FAIL ovr_data row %0d idx=%0d data_ok=%b (want %0d,1)",
                         r, d_bus.row_index_out, d_bus.row_data_out === exp_row(0, r), r);
            end
            d_bus.matrix_valid_in = (r == 20 || r == 40);
            if (r == 20) d_bus.y_matrix_flat_in = frame(1);
            @(negedge clk);
        end
        d_bus.matrix_valid_in = 1'b0;
        n_cmp++;
        if (d_done !== 1'b1 || d_ovr !== 8'd2) begin
            n_err++;
            $display("FAIL ovr_count done=%b ovr=%0d (want 1,2)", d_done, d_ovr);
        end
        @(negedge clk);
        d_bus.row_ready_in = 1'b0;
        pulse_frame(0);
        d_bus.matrix_valid_in  = 1'b1;
        d_bus.y_matrix_flat_in = frame(1);
        repeat (252) @(negedge clk);
        n_cmp++;
        if (d_ovr !== 8'd254) begin
            n_err++;
            $display("FAIL ovr_254 ovr=%0d (want 254)", d_ovr);
        end
        repeat (5) @(negedge clk);
        d_bus.matrix_valid_in = 1'b0;
        n_cmp++;
        if (d_ovr !== 8'd255) begin
            n_err++;
            $display("FAIL ovr_saturate ovr=%0d (want 255)", d_ovr);
        end
        n_cmp++;
        if (d_bus.row_index_out !== 6'd0 || d_bus.row_data_out !== exp_row(0, 0)) begin
            n_err++;
            $display("FAIL ovr_buffer idx=%0d data_ok=%b (want 0,1)",
                     d_bus.row_index_out, d_bus.row_data_out === exp_row(0, 0));
        end
        drain_big("ovr");
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_bus.row_ready_in = 1'b1;
        pulse_frame(0);
        repeat (N - 1) @(negedge clk);
        n_cmp++;
        if (d_bus.row_index_out !== 6'd63 || d_bus.row_last_out !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_last idx=%0d last=%b (want 63,1)", d_bus.row_index_out, d_bus.row_last_out);
        end
        pulse_frame(2);
        n_cmp++;
        if (d_done !== 1'b1 || d_busy !== 1'b1 || d_bus.row_valid_out !== 1'b1 ||
            d_bus.row_index_out !== 6'd0 || d_ovr !== 8'd0 || d_bus.row_data_out !== exp_row(2, 0)) begin
            n_err++;
            $display("FAIL b2b_chain done=%b busy=%b valid=%b idx=%0d ovr=%0d data_ok=%b (want 1,1,1,0,0,1)",
                     d_done, d_busy, d_bus.row_valid_out, d_bus.row_index_out, d_ovr,
                     d_bus.row_data_out === exp_row(2, 0));
        end
        for (int r = 1; r < N; r++) begin
            @(negedge clk);
            n_cmp++;
            if (d_bus.row_index_out !== 6'(r) || d_done !== 1'b0 || d_bus.row_data_out !== exp_row(2, r)) begin
                n_err++;
                $display("FAIL b2b_data row %0d idx=%0d done=%b data_ok=%b (want %0d,0,1)",
                         r, d_bus.row_index_out, d_done, d_bus.row_data_out === exp_row(2, r), r);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (d_done !== 1'b1 || d_busy !== 1'b0 || d_ovr !== 8'd0) begin
            n_err++;
            $display("FAIL b2b_end done=%b busy=%b ovr=%0d (want 1,0,0)", d_done, d_busy, d_ovr);
        end
        @(negedge clk);
    endtask

    task automatic test_small_params();
        int  exp_r;
        int  k;
        bit  seen_done;
        bit  rdy;
        for (int f = 0; f < 3; f++) begin
            s_bus.row_ready_in     = 1'b0;
            s_bus.matrix_valid_in  = 1'b1;
            s_bus.y_matrix_flat_in = sframe(f);
            @(negedge clk);
            s_bus.matrix_valid_in  = 1'b0;
            exp_r     = 0;
            k         = 0;
            seen_done = 1'b0;
            while (!seen_done && k < 100) begin
                if (s_bus.row_valid_out === 1'b1) begin
                    n_cmp++;
                    if (exp_r > NS - 1 || s_bus.row_index_out !== 2'(exp_r) ||
                        s_bus.row_data_out !== exp_srow(f, exp_r) ||
                        s_bus.row_last_out !== (exp_r == NS - 1)) begin
                        n_err++;
                        $display("FAIL small_row frame %0d idx=%0d data=%h last=%b (want %0d,%h,%b)",
                                 f, s_bus.row_index_out, s_bus.row_data_out, s_bus.row_last_out,
                                 exp_r, exp_srow(f, exp_r), (exp_r == NS - 1));
                    end
                end
                if (s_done === 1'b1) begin
                    seen_done = 1'b1;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                    s_bus.row_ready_in = rdy;
                    if (s_bus.row_valid_out === 1'b1 && rdy) exp_r++;
                    @(negedge clk);
                    k++;
                end
            end
            n_cmp++;
            if (!seen_done || exp_r != NS || s_ovr !== 8'd0) begin
                n_err++;
                $display("FAIL small_frame %0d done_seen=%b rows=%0d ovr=%0d (want 1,%0d,0)",
                         f, seen_done, exp_r, s_ovr, NS);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        d_bus.matrix_valid_in  = 1'b0;
        d_bus.y_matrix_flat_in = '0;
        d_bus.row_ready_in     = 1'b0;
        s_bus.matrix_valid_in  = 1'b0;
        s_bus.y_matrix_flat_in = '0;
        s_bus.row_ready_in     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_full_rate();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_small_params();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/layer_norm_row_streamer.md
# layer_norm_row_streamer

Consumer of the LayerNorm matrix engine's completed output frame. Captures the full flattened MATRIX_SIZE×MATRIX_SIZE result on the engine's one-cycle `matrix_done` pulse. Replays the frame one row per transfer over a valid/ready stream to downstream row-wise units (e.g. the next attention/FFN stage). Frame arrivals that collide with an in-progress replay are counted and dropped.

## Interface
- MATRIX_SIZE, 64, rows per frame and elements per row
- Y_WIDTH, 16, bits per element (Q5.10 signed; not interpreted here)
- ROW_IDX_WIDTH, $clog2(MATRIX_SIZE), width of the row index
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- matrix_valid_in  input  1  one-cycle frame-available pulse (driven by engine `matrix_done`)
- y_matrix_flat_in  input  MATRIX_SIZE*MATRIX_SIZE*Y_WIDTH  frame; row r at bits [r*MATRIX_SIZE*Y_WIDTH +: MATRIX_SIZE*Y_WIDTH]
- row_ready_in  input  1  downstream accepts the current row
- row_valid_out  output  1  row_data_out holds a valid row
- row_data_out  output  MATRIX_SIZE*Y_WIDTH  current row slice of the captured frame
- row_index_out  output  ROW_IDX_WIDTH  index of the row on row_data_out
- row_last_out  output  1  high with row_valid_out when row_index_out == MATRIX_SIZE-1
- frame_done_out  output  1  one-cycle pulse after the final row transfers
- busy_out  output  1  high while a frame is being replayed
- overrun_count_out  output  8  dropped-frame count, saturating at 255

## Operation
- States: IDLE, STREAM.
- IDLE, matrix_valid_in=1:
  - capture y_matrix_flat_in into the frame buffer
  - row counter ← 0
  - go to STREAM
- STREAM:
  - row_valid_out=1 and busy_out=1
  - row_data_out = buffer slice at the row counter; row_index_out = row counter
  - Transfer occurs when row_valid_out && row_ready_in.
  - On a non-final transfer: row counter +1.
  - On the final transfer (counter == MATRIX_SIZE-1): frame_done_out pulses next cycle. Then:
    - if matrix_valid_in is high in that same cycle: capture the new frame, counter ← 0, stay in STREAM (no bubble, no overrun)
    - else go to IDLE
- matrix_valid_in in STREAM on any cycle except a final transfer: frame dropped, buffer untouched, overrun_count_out +1 (saturate 255).
- Backpressure: while row_valid_out=1 and row_ready_in=0, row_data_out, row_index_out and row_last_out hold stable.
- row_ready_in is ignored in IDLE.
- Buffer is written only on accepted captures, so the replayed data never changes mid-frame.
- Outputs are the buffer slice, unmodified; no arithmetic on data.

## Timing
- Reset (rst high at a clock edge):
  - state IDLE; row counter 0; overrun count 0
  - buffer cleared to 0
  - all outputs 0
  - Reset mid-frame abandons the frame with no frame_done_out.
- Capture latency: matrix_valid_in sampled at edge T → row_valid_out high, row 0 presented, from just after T (visible cycle T+1).
- Throughput: one row per cycle with row_ready_in held high. A frame takes MATRIX_SIZE cycles.
- frame_done_out: high exactly one cycle, the cycle after the final transfer edge.
- Back-to-back frames with the new pulse coincident with the final transfer: row 0 of the new frame appears in the same cycle frame_done_out pulses.
- busy_out and row_valid_out are equal at all times.
- Row outputs are registered state plus a slice mux; no combinational path from row_ready_in to row_data_out.

## Test plan
- Reset/idle:
  - Stimulus: assert rst for 2 cycles mid-stream (frame loaded, row 5 pending), then release.
  - Required: all outputs 0; no frame_done_out; row_ready_in toggling in IDLE causes no activity.
- Full-rate replay:
  - Stimulus: element (r,c) = r*64+c; pulse matrix_valid_in; hold row_ready_in=1.
  - Required: rows 0..63 on 64 consecutive cycles; row_data_out element c equals r*64+c; row_last_out only at index 63; frame_done_out one cycle later; busy_out falls with it.
- Backpressure:
  - Stimulus: row_ready_in low for 3 cycles while row 10 is presented, then high.
  - Required: row 10 data and index held for 4 cycles; single transfer of row 10; row 11 follows.
- Overrun:
  - Stimulus: second matrix_valid_in (new data all 0x7FFF) at row 20; third pulse at row 40.
  - Required: remaining rows still show the original frame; overrun_count_out = 2; 257 drops in a long run read 255.
- Back-to-back:
  - Stimulus: new frame pulse coincident with the row-63 transfer.
  - Required: next cycle frame_done_out=1, row_index_out=0 with new data, busy_out stays 1, overrun_count_out unchanged.
- Small parameter set:
  - Stimulus: MATRIX_SIZE=4, Y_WIDTH=8, random ready pattern.
  - Required: all 4 rows per frame delivered in order, matching a scoreboard.
